// File: rtl/tick_sup_pkg.sv
// Shared types and default window bounds for the tick supervisor.
// Window bounds are inclusive interval lengths in clock cycles.
package tick_sup_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_LOCKED,
        ST_FAULT
    } tick_sup_state_e;

    localparam int PERIOD_DEF = 15001;
    localparam int TOL_DEF    = 2;
    localparam int WIN_LO     = PERIOD_DEF - TOL_DEF;
    localparam int WIN_HI     = PERIOD_DEF + TOL_DEF;

endpackage

// File: rtl/tick_interval_ctr.sv
// Cycles-since-last-tick counter with window classification.
// Saturates at the window top so the timeout stays asserted.
module tick_interval_ctr
    import tick_sup_pkg::*;
#(
    parameter int CBITS = 15,
    parameter int WLO   = WIN_LO,
    parameter int WHI   = WIN_HI
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick_in,
    output logic [CBITS:0] interval,
    output logic           good,
    output logic           timeout
);

    logic [CBITS-1:0] ival_q;
    logic [CBITS-1:0] ival_d;
    logic             at_top;

    always_comb begin
        at_top   = (ival_q == CBITS'(WHI));
        interval = {1'b0, ival_q} + 1'b1;
        good     = (interval >= (CBITS+1)'(WLO)) &&
                   (interval <= (CBITS+1)'(WHI));
        timeout  = !tick_in && at_top;
        ival_d   = ival_q;
        if (tick_in) begin
            ival_d = '0;
        end else if (!at_top) begin
            ival_d = ival_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ival_q <= '0;
        end else begin
            ival_q <= ival_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (ival_q <= CBITS'(WHI))
            else $error("ival above window top");
        end
    end

endmodule

// File: rtl/tick_supervisor.sv
// Tick spacing supervisor: acquires lock on a run of in-window
// intervals and latches a fault on a bad or missing tick once locked.
module tick_supervisor
    import tick_sup_pkg::*;
#(
    parameter int PERIOD   = PERIOD_DEF,
    parameter int TOL      = TOL_DEF,
    parameter int LOCK_CNT = 4,
    parameter int CBITS    = 15,
    parameter int TCBITS   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    output logic              locked,
    output logic              fault,
    output logic              miss,
    output logic [TCBITS-1:0] tick_cnt
);

    localparam int GBITS = $clog2(LOCK_CNT + 1);

    logic [CBITS:0]    interval;
    logic              good;
    logic              timeout;

    tick_sup_state_e   state_q, state_d;
    logic [GBITS-1:0]  good_cnt_q, good_cnt_d;
    logic [TCBITS-1:0] tick_cnt_q, tick_cnt_d;
    logic              locked_q, locked_d;
    logic              fault_q, fault_d;
    logic              miss_q, miss_d;

    tick_interval_ctr #(
        .CBITS(CBITS),
        .WLO  (PERIOD - TOL),
        .WHI  (PERIOD + TOL)
    ) u_ctr (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .interval(interval),
        .good    (good),
        .timeout (timeout)
    );

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        tick_cnt_d = tick_cnt_q;
        miss_d     = 1'b0;

        if (tick_in && tick_cnt_q != '1) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                // interval measured from reset or a dropout is meaningless
                if (tick_in) begin
                    state_d    = ST_ACQ;
                    good_cnt_d = '0;
                end
            end
            ST_ACQ: begin
                if (tick_in && good) begin
                    good_cnt_d = good_cnt_q + 1'b1;
                    if (good_cnt_d == GBITS'(LOCK_CNT)) begin
                        state_d = ST_LOCKED;
                    end
                end else if (tick_in) begin
                    good_cnt_d = '0;
                end else if (timeout) begin
                    state_d    = ST_IDLE;
                    good_cnt_d = '0;
                    miss_d     = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (tick_in && !good) begin
                    state_d = ST_FAULT;
                end else if (timeout) begin
                    state_d = ST_FAULT;
                    miss_d  = 1'b1;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
        fault_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            good_cnt_q <= '0;
            tick_cnt_q <= '0;
            locked_q   <= 1'b0;
            fault_q    <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            locked_q   <= locked_d;
            fault_q    <= fault_d;
            miss_q     <= miss_d;
        end
    end

    assign locked   = locked_q;
    assign fault    = fault_q;
    assign miss     = miss_q;
    assign tick_cnt = tick_cnt_q;

    a_fault_not_locked: assert property (
        @(posedge clk) fault_q |-> !locked_q
    ) else $error("fault and locked together");

    a_miss_single: assert property (
        @(posedge clk) disable iff (rst) miss_q |=> !miss_q
    ) else $error("miss held two cycles");

    a_interval_range: assert property (
        @(posedge clk) disable iff (rst)
        interval <= (CBITS+1)'(PERIOD + TOL + 1)
    ) else $error("interval out of range");

`ifdef FORMAL
    p_live: assert property (
        (always s_eventually rst) or (s_eventually always locked)
    );
`endif

endmodule

// File: tb/tb_tick_supervisor.sv
// Randomized and directed stimulus for tick_supervisor, checked
// every cycle against a behavioural model of the supervisor rules.
module tb_tick_supervisor;

    localparam int PERIOD   = 8;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 3;
    localparam int CBITS    = 5;
    localparam int TCBITS   = 6;
    localparam int LO       = PERIOD - TOL;
    localparam int HI       = PERIOD + TOL;
    localparam int TMAX     = (1 << TCBITS) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_ACQ    = 1;
    localparam int M_LOCK   = 2;
    localparam int M_FAULT  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              tick_in = 1'b0;
    logic              locked;
    logic              fault;
    logic              miss;
    logic [TCBITS-1:0] tick_cnt;

    int checks = 0;
    int errors = 0;

    int m_st   = M_IDLE;
    int m_gap  = 0;
    int m_run  = 0;
    int m_cnt  = 0;
    int m_miss = 0;
    logic prev_miss = 1'b0;

    tick_supervisor #(
        .PERIOD  (PERIOD),
        .TOL     (TOL),
        .LOCK_CNT(LOCK_CNT),
        .CBITS   (CBITS),
        .TCBITS  (TCBITS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .locked  (locked),
        .fault   (fault),
        .miss    (miss),
        .tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Supervisor rules applied to one clock edge.
    task automatic model(input bit t, input bit r);
        int  len;
        bit  in_win;
        bit  late;
        if (r) begin
            m_st = M_IDLE; m_gap = 0; m_run = 0;
            m_cnt = 0; m_miss = 0;
            return;
        end
        len    = m_gap + 1;
        in_win = (len >= LO) && (len <= HI);
        late   = !t && (m_gap >= HI);
        m_miss = 0;
        case (m_st)
            M_IDLE: if (t) begin m_st = M_ACQ; m_run = 0; end
            M_ACQ: begin
                if (t && in_win) begin
                    m_run++;
                    if (m_run == LOCK_CNT) m_st = M_LOCK;
                end else if (t) begin
                    m_run = 0;
                end else if (late) begin
                    m_st = M_IDLE; m_run = 0; m_miss = 1;
                end
            end
            M_LOCK: begin
                if (t && !in_win) m_st = M_FAULT;
                else if (late) begin m_st = M_FAULT; m_miss = 1; end
            end
            default: ;
        endcase
        if (t && m_cnt < TMAX) m_cnt++;
        if (t) m_gap = 0;
        else if (m_gap < HI) m_gap++;
    endtask

    task automatic cyc(input bit t, input bit r);
        @(negedge clk);
        tick_in = t;
        rst     = r;
        @(posedge clk);
        model(t, r);
        #1;
        chk("locked", locked, 32'(m_st == M_LOCK));
        chk("fault", fault, 32'(m_st == M_FAULT));
        chk("miss", miss, 32'(m_miss));
        chk("tick_cnt", tick_cnt, 32'(m_cnt));
        chk("inv_fault_lock", fault & locked, 0);
        chk("inv_miss_twice", prev_miss & miss, 0);
        prev_miss = miss;
    endtask

    task automatic tick_after(input int n);
        for (int i = 1; i < n; i++) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
    endtask

    task automatic reset_dut();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
    endtask

    task automatic wait_miss(input string tag);
        int hit;
        hit = 0;
        for (int i = 1; i <= 20 && hit == 0; i++) begin
            cyc(1'b0, 1'b0);
            if (miss) hit = i;
        end
        chk(tag, hit, HI + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        cyc(1'b0, 1'b1);
        chk("rst_locked", locked, 0);
        chk("rst_fault", fault, 0);
        chk("rst_cnt", tick_cnt, 0);

        // nominal lock
        cyc(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) tick_after(PERIOD);
        chk("pre_lock", locked, 0);
        tick_after(PERIOD);
        chk("lock_4th", locked, 1);
        chk("lock_cnt4", tick_cnt, 4);
        chk("lock_nofault", fault, 0);

        // late tick while locked
        tick_after(HI + 1);
        chk("late_fault", fault, 1);
        chk("late_unlock", locked, 0);
        for (int k = 0; k < 3; k++) tick_after(PERIOD);
        chk("fault_sticky", fault, 1);
        chk("fault_cnt", tick_cnt, 8);

        // dropout while locked
        reset_dut();
        for (int k = 0; k < 4; k++) tick_after(PERIOD);
        wait_miss("miss_locked_at");
        chk("miss_locked_flt", fault, 1);
        cyc(1'b0, 1'b0);
        chk("miss_one_cycle", miss, 0);
        chk("miss_flt_hold", fault, 1);

        // short interval during acquisition
        reset_dut();
        tick_after(PERIOD);
        tick_after(8); tick_after(6); tick_after(8); tick_after(8);
        chk("acq_not_yet", locked, 0);
        tick_after(8);
        chk("acq_locked", locked, 1);

        // dropout during acquisition, then relock
        reset_dut();
        tick_after(PERIOD);
        tick_after(PERIOD);
        wait_miss("miss_acq_at");
        chk("miss_acq_flt", fault, 0);
        chk("miss_acq_lock", locked, 0);
        for (int k = 0; k < 3; k++) tick_after(PERIOD);
        chk("relock_pre", locked, 0);
        tick_after(PERIOD);
        chk("relock", locked, 1);

        // edge windows: LO and HI accepted while locked
        tick_after(LO);
        tick_after(HI);
        chk("win_edges", locked, 1);

        // reset with coincident tick
        for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        chk("rst_tick_lock", locked, 0);
        chk("rst_tick_cnt", tick_cnt, 0);
        chk("rst_tick_flt", fault, 0);
        chk("rst_tick_miss", miss, 0);

        // counter saturation
        cyc(1'b0, 1'b0);
        for (int k = 0; k < TMAX + 6; k++) tick_after(PERIOD);
        chk("cnt_sat", tick_cnt, TMAX);

        // random spacing
        reset_dut();
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 3)       cyc(1'b0, 1'b1);
            else if (r < 70) tick_after(PERIOD);
            else if (r < 78) tick_after(LO);
            else if (r < 86) tick_after(HI);
            else if (r < 91) tick_after(LO - 1);
            else if (r < 95) tick_after(HI + 1);
            else             tick_after($urandom_range(HI + 2, HI + 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
